// File: rtl/sif_xa_master.sv
// sif_xa_master: queued read/write initiator for the SIF xa access bus.
// Define SIF_XA_MASTER_WR_ACK_EN to also report write completions on the rsp port.
module sif_xa_master #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int FIFO_DEP = 4,
    parameter int RD_LAT   = 1,
    parameter int GAP      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] xa_addr,
    output logic [DATA_W-1:0] xa_data_wr,
    output logic              xa_wr_s,
    output logic              xa_rd_s,
    input  logic [DATA_W-1:0] xa_data_rd,
    output logic              rsp_valid,
    output logic              rsp_op,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEP);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    localparam logic [1:0]       S_AFTER = (GAP > 0) ? S_GAP : S_IDLE;
    localparam logic [3:0]       GAP_CNT = 4'(GAP);
    localparam logic [LAT_W-1:0] LAT_CNT = LAT_W'(RD_LAT);

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t             fifo_mem [FIFO_DEP];
    cmd_t             head;
    logic [PTR_W:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic             push, pop, empty, full_nxt;
    logic [1:0]       state;
    logic [LAT_W-1:0] lat_cnt;
    logic [3:0]       gap_cnt;
`ifdef SIF_XA_MASTER_WR_ACK_EN
    logic             wr_ack_pend;
`endif

    assign push       = cmd_valid && cmd_ready;
    assign empty      = (wr_ptr == rd_ptr);
    assign pop        = (state == S_IDLE) && !empty;
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign wr_ptr_nxt = wr_ptr + {{PTR_W{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{PTR_W{1'b0}}, pop};
    // Full when the index bits match but the wrap bits differ.
    assign full_nxt   = (wr_ptr_nxt[PTR_W] != rd_ptr_nxt[PTR_W]) &&
                        (wr_ptr_nxt[PTR_W-1:0] == rd_ptr_nxt[PTR_W-1:0]);
    assign busy       = !empty || (state != S_IDLE);

    // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_op, cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_ready <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            cmd_ready <= !full_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            gap_cnt    <= '0;
            xa_addr    <= '0;
            xa_data_wr <= '0;
            xa_wr_s    <= 1'b0;
            xa_rd_s    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_op     <= 1'b0;
            rsp_addr   <= '0;
            rsp_data   <= '0;
`ifdef SIF_XA_MASTER_WR_ACK_EN
            wr_ack_pend <= 1'b0;
`endif
        end else begin
            // NOTE: pulses default low every edge, so each can only be high for one cycle.
            xa_wr_s   <= 1'b0;
            xa_rd_s   <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        xa_addr    <= head.addr;
                        xa_data_wr <= head.op ? head.data : '0;
                        xa_wr_s    <= head.op;
                        xa_rd_s    <= !head.op;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (xa_wr_s) begin
                        gap_cnt <= GAP_CNT;
                        state   <= S_AFTER;
                    end else begin
                        lat_cnt <= LAT_CNT;
                        state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        rsp_valid <= 1'b1;
                        rsp_op    <= 1'b0;
                        rsp_addr  <= xa_addr;
                        rsp_data  <= xa_data_rd;
                        gap_cnt   <= GAP_CNT;
                        state     <= S_AFTER;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd1) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef SIF_XA_MASTER_WR_ACK_EN
            // xa_addr still holds the write address here even if a new pop loads it this edge.
            wr_ack_pend <= (state == S_ISSUE) && xa_wr_s;
            if (wr_ack_pend) begin
                rsp_valid <= 1'b1;
                rsp_op    <= 1'b1;
                rsp_addr  <= xa_addr;
                rsp_data  <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sif_xa_master.sv
// tb_sif_xa_master: directed and randomized checks of sif_xa_master against a
// transaction-level model (command queue plus issue/response timing rules).
module tb_sif_xa_master;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int FIFO_DEP = 4;
    localparam int RD_LAT   = 1;
    localparam int GAP      = 3;
`ifdef SIF_XA_MASTER_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready, cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] xa_addr;
    logic [DATA_W-1:0] xa_data_wr, xa_data_rd;
    logic              xa_wr_s, xa_rd_s;
    logic              rsp_valid, rsp_op;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    always #5 clk = ~clk;

    sif_xa_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEP(FIFO_DEP), .RD_LAT(RD_LAT), .GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
        .xa_data_rd(xa_data_rd),
        .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SIF core stand-in: memory with RD_LAT read latency ----------------
    bit [DATA_W-1:0] core_mem [65536];
    int              rd_pend;
    bit [DATA_W-1:0] rd_hold;

    initial begin
        xa_data_rd = '0;
        rd_pend    = 0;
        forever begin
            @(negedge clk);
            // Garbage except on the one cycle the read data is due.
            xa_data_rd = 16'($urandom);
            if (rd_pend != 0) begin
                rd_pend--;
                if (rd_pend == 0) xa_data_rd = rd_hold;
            end
            if (xa_wr_s) core_mem[xa_addr] = xa_data_wr;
            if (xa_rd_s) begin
                rd_pend = RD_LAT;
                rd_hold = core_mem[xa_addr];
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        bit              op;
        bit [ADDR_W-1:0] addr;
        bit [DATA_W-1:0] data;
    } cmd_t;
    typedef struct {
        longint          due;
        bit              op;
        bit [ADDR_W-1:0] addr;
        bit [DATA_W-1:0] data;
    } rsp_t;

    cmd_t            mq[$];
    rsp_t            rq[$];
    bit [DATA_W-1:0] model_mem [65536];
    longint          edge_n = 0;
    longint          next_ok;
    bit              e_wr, e_rd, e_rv, e_rop, e_ready, e_busy, ready_known;
    bit [ADDR_W-1:0] e_addr, e_raddr;
    bit [DATA_W-1:0] e_wdata, e_rdata;

    task automatic model_reset();
        mq.delete();
        rq.delete();
        next_ok = 0;
        {e_wr, e_rd, e_rv, e_rop, e_ready, e_busy, ready_known} = '0;
        e_addr = '0; e_raddr = '0; e_wdata = '0; e_rdata = '0;
    endtask

    task automatic model_step();
        cmd_t c;
        rsp_t r;
        edge_n++;
        e_wr = 1'b0;
        e_rd = 1'b0;
        e_rv = 1'b0;
        // Issue the oldest command once the previous one's spacing has elapsed.
        if (mq.size() != 0 && edge_n >= next_ok) begin
            c       = mq.pop_front();
            e_wr    = c.op;
            e_rd    = !c.op;
            e_addr  = c.addr;
            e_wdata = c.op ? c.data : '0;
            if (c.op) begin
                model_mem[c.addr] = c.data;
                next_ok = edge_n + 2 + GAP;
                if (WR_ACK) begin
                    r = '{edge_n + 2, 1'b1, c.addr, '0};
                    rq.push_back(r);
                end
            end else begin
                next_ok = edge_n + 2 + RD_LAT + GAP;
                r = '{edge_n + 1 + RD_LAT, 1'b0, c.addr, model_mem[c.addr]};
                rq.push_back(r);
            end
        end
        if (rq.size() != 0 && rq[0].due == edge_n) begin
            r       = rq.pop_front();
            e_rv    = 1'b1;
            e_rop   = r.op;
            e_raddr = r.addr;
            e_rdata = r.data;
        end
        if (cmd_valid && e_ready) mq.push_back('{cmd_op, cmd_addr, cmd_data});
        e_ready     = (mq.size() < FIFO_DEP);
        e_busy      = (mq.size() != 0) || (edge_n < next_ok - 1);
        ready_known = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- compare and stimulus ----------------
    int              neg_n = 0;
    bit              saw_full;
    bit [ADDR_W-1:0] strobe_addr_q[$];
    int              strobe_cyc_q[$];

    task automatic compare_all();
        check("xa_wr_s", xa_wr_s, e_wr);
        check("xa_rd_s", xa_rd_s, e_rd);
        check("xa_addr", xa_addr, e_addr);
        check("xa_data_wr", xa_data_wr, e_wdata);
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_op", rsp_op, e_rop);
        check("rsp_addr", rsp_addr, e_raddr);
        check("rsp_data", rsp_data, e_rdata);
        check("busy", busy, e_busy);
        if (ready_known) begin
            check("cmd_ready", cmd_ready, e_ready);
            if (cmd_ready === 1'b0) saw_full = 1'b1;
        end
        if (xa_wr_s || xa_rd_s) begin
            strobe_addr_q.push_back(xa_addr);
            strobe_cyc_q.push_back(neg_n);
        end
        neg_n++;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    // Offer one command and return at the negedge just after the accepting edge.
    task automatic push_cmd(input bit op, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("push_accept_in_time", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || e_busy || rq.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check("idle_in_time", busy, 0);
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        repeat (3) tick();
        check("rst_xa_wr_s", xa_wr_s, 0);
        check("rst_xa_addr", xa_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_release", cmd_ready, 1);

        // Single write: strobe one edge after acceptance, one cycle wide.
        push_cmd(1'b1, 16'h0010, 16'hA5A5);
        check("wr_not_yet", xa_wr_s, 0);
        tick();
        check("wr_strobe", xa_wr_s, 1);
        check("wr_rd_s_low", xa_rd_s, 0);
        check("wr_addr", xa_addr, 16'h0010);
        check("wr_data", xa_data_wr, 16'hA5A5);
        tick();
        check("wr_one_cycle", xa_wr_s, 0);
        check("wr_addr_hold", xa_addr, 16'h0010);
        wait_idle();

        // Read back: response two cycles after the strobe.
        push_cmd(1'b0, 16'h0010, 16'h1234);
        tick();
        check("rd_strobe", xa_rd_s, 1);
        check("rd_addr", xa_addr, 16'h0010);
        check("rd_wdata_zero", xa_data_wr, 0);
        tick();
        check("rd_rsp_not_yet", rsp_valid, 0);
        tick();
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_op", rsp_op, 0);
        check("rd_rsp_addr", rsp_addr, 16'h0010);
        check("rd_rsp_data", rsp_data, 16'hA5A5);
        tick();
        check("rd_rsp_one_cycle", rsp_valid, 0);
        check("rd_rsp_data_hold", rsp_data, 16'hA5A5);
        wait_idle();

        // Five back-to-back writes: order kept, FIFO fills, strobes spaced 2+GAP = 5.
        saw_full = 1'b0;
        strobe_addr_q.delete();
        strobe_cyc_q.delete();
        for (int i = 0; i < 5; i++) push_cmd(1'b1, 16'(16'h0100 + i), 16'(16'hC000 + i));
        wait_idle();
        check("b2b_full_seen", saw_full, 1);
        check("b2b_count", strobe_addr_q.size(), 5);
        for (int i = 0; i < 5 && i < strobe_addr_q.size(); i++) begin
            check("b2b_order", strobe_addr_q[i], 16'(16'h0100 + i));
            if (i > 0) check("b2b_spacing", strobe_cyc_q[i] - strobe_cyc_q[i-1], 5);
        end

        // Reset while waiting for read data: the read is dropped silently.
        push_cmd(1'b0, 16'h0101, 16'h0000);
        tick();
        check("rstrd_strobe", xa_rd_s, 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rstrd_rd_s", xa_rd_s, 0);
        check("rstrd_addr", xa_addr, 0);
        check("rstrd_rsp_valid", rsp_valid, 0);
        check("rstrd_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstrd_no_rsp", rsp_valid, 0);
        end
        check("rstrd_ready", cmd_ready, 1);
        check("rstrd_busy_after", busy, 0);

        // Randomized traffic with varying load and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            int load;
            load      = (c < 1000) ? 25 : ((c < 2000) ? 60 : 95);
            cmd_valid = ($urandom_range(0, 99) < load);
            cmd_op    = 1'($urandom_range(0, 1));
            cmd_addr  = 16'($urandom_range(0, 31));
            cmd_data  = 16'($urandom);
            if (c == 1234 || c == 2468) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        cmd_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
